// File: rtl/mbist_pkg.sv
// mbist_pkg: shared encodings for the March C- sequencer.
// No ports: FSM states, element ids M0..M5 and the per-element op table.
package mbist_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  typedef enum logic [2:0] {
    M0 = 3'd0,
    M1 = 3'd1,
    M2 = 3'd2,
    M3 = 3'd3,
    M4 = 3'd4,
    M5 = 3'd5
  } elem_t;

  localparam elem_t LAST_ELEM = M5;

  // rd/wr: which ops the element has (read first when both).
  // rval/wval: background bit expected on read / written.
  typedef struct packed {
    logic down;
    logic rd;
    logic wr;
    logic rval;
    logic wval;
  } elem_op_t;

  function automatic logic elem_down(elem_t e);
    return (e == M3) || (e == M4);
  endfunction

  function automatic elem_op_t elem_op(elem_t e);
    elem_op_t o;
    o = '0;
    o.down = elem_down(e);
    unique case (e)
      M0: {o.rd, o.wr, o.rval, o.wval} = 4'b0100;
      M1: {o.rd, o.wr, o.rval, o.wval} = 4'b1101;
      M2: {o.rd, o.wr, o.rval, o.wval} = 4'b1110;
      M3: {o.rd, o.wr, o.rval, o.wval} = 4'b1101;
      M4: {o.rd, o.wr, o.rval, o.wval} = 4'b1110;
      M5: {o.rd, o.wr, o.rval, o.wval} = 4'b1000;
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/mbist_fail_capture.sv
// mbist_fail_capture: read-data comparator with sticky first-fail capture.
// In: read strobe/expect/addr/elem (issue cycle), rdata; out: fail, addr, elem.
module mbist_fail_capture
  import mbist_pkg::*;
#(
  parameter int AWIDTH = 4,
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic              i_re,
  input  logic              i_exp,
  input  logic [AWIDTH-1:0] i_addr,
  input  elem_t             i_elem,
  input  logic [DWIDTH-1:0] i_rdata,
  output logic              o_fail,
  output logic [AWIDTH-1:0] o_fail_addr,
  output elem_t             o_fail_elem
);

  logic              r_chk;
  logic              r_exp;
  logic [AWIDTH-1:0] r_addr;
  elem_t             r_elem;
  logic              r_fail;
  logic [AWIDTH-1:0] r_fail_addr;
  elem_t             r_fail_elem;
  logic              w_miss;

  // Read tag follows data by one cycle, so a miscompare
  // reports the element of the read even across a wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_chk  <= 1'b0;
      r_exp  <= 1'b0;
      r_addr <= '0;
      r_elem <= M0;
    end else begin
      r_chk  <= i_re;
      r_exp  <= i_exp;
      r_addr <= i_addr;
      r_elem <= i_elem;
    end
  end

  assign w_miss = r_chk & i_en &
                  (i_rdata != {DWIDTH{r_exp}});

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_fail      <= 1'b0;
      r_fail_addr <= '0;
      r_fail_elem <= M0;
    end else if (w_miss && !r_fail) begin
      r_fail      <= 1'b1;
      r_fail_addr <= r_addr;
      r_fail_elem <= r_elem;
    end
  end

  assign o_fail      = r_fail;
  assign o_fail_addr = r_fail_addr;
  assign o_fail_elem = r_fail_elem;

endmodule

// File: rtl/mbist_march_seq.sv
// mbist_march_seq: March C- memory BIST sequencer, one op per cycle.
// In: clk, rst, test_mode, start, mem_rdata; out: mem_*, busy, done, status, fail info.
module mbist_march_seq
  import mbist_pkg::*;
#(
  parameter int AWIDTH = 4,
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              test_mode,
  input  logic              start,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              bist_status,
  output logic [AWIDTH-1:0] fail_addr,
  output logic [2:0]        fail_elem
);

  state_t            r_state;
  state_t            w_next;
  logic [AWIDTH-1:0] r_addr;
  elem_t             r_elem;
  elem_t             w_elem_nxt;
  logic              r_ph;
  elem_op_t          w_op;
  logic              w_is_rd;
  logic              w_last_op;
  logic              w_addr_end;
  logic              w_final;
  logic              w_go;
  logic              w_accept;
  logic              w_run;
  logic              w_fail;
  logic [AWIDTH-1:0] w_fail_addr;
  elem_t             w_fail_elem;

  assign w_op       = elem_op(r_elem);
  assign w_is_rd    = w_op.rd & ~r_ph;
  // Phase 1 only exists for read-then-write elements.
  assign w_last_op  = ~(w_op.rd & w_op.wr) | r_ph;
  assign w_addr_end = w_op.down ? (r_addr == '0)
                                : (r_addr == '1);
  assign w_final    = (r_elem == LAST_ELEM) &
                      w_addr_end & w_last_op;
  assign w_go       = start & test_mode;
  assign w_accept   = w_go & ((r_state == S_IDLE) |
                              (r_state == S_DONE));
  assign w_run      = (r_state == S_RUN);
  assign w_elem_nxt = elem_t'(r_elem + 3'd1);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: if (w_go) w_next = S_RUN;
      S_RUN: begin
        if (!test_mode)   w_next = S_IDLE;
        else if (w_final) w_next = S_FLUSH;
      end
      S_FLUSH: begin
        if (!test_mode) w_next = S_IDLE;
        else            w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || w_accept) begin
      r_addr <= '0;
      r_elem <= M0;
      r_ph   <= 1'b0;
    end else if (w_run) begin
      if (!w_last_op) begin
        r_ph <= 1'b1;
      end else begin
        r_ph <= 1'b0;
        if (w_addr_end) begin
          if (!w_final) begin
            r_elem <= w_elem_nxt;
            r_addr <= elem_down(w_elem_nxt) ? '1 : '0;
          end
        end else if (w_op.down) begin
          r_addr <= r_addr - 1'b1;
        end else begin
          r_addr <= r_addr + 1'b1;
        end
      end
    end
  end

  mbist_fail_capture #(
    .AWIDTH(AWIDTH),
    .DWIDTH(DWIDTH)
  ) u_cap (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_accept),
    .i_en       (busy),
    .i_re       (mem_re),
    .i_exp      (w_op.rval),
    .i_addr     (r_addr),
    .i_elem     (r_elem),
    .i_rdata    (mem_rdata),
    .o_fail     (w_fail),
    .o_fail_addr(w_fail_addr),
    .o_fail_elem(w_fail_elem)
  );

  always_comb begin
    mem_we      = w_run & ~w_is_rd;
    mem_re      = w_run & w_is_rd;
    mem_addr    = w_run ? r_addr : '0;
    mem_wdata   = (w_run & ~w_is_rd) ?
                  {DWIDTH{w_op.wval}} : '0;
    busy        = w_run | (r_state == S_FLUSH);
    done        = (r_state == S_DONE);
    bist_status = done & ~w_fail;
    fail_addr   = w_fail_addr;
    fail_elem   = w_fail_elem;
  end

endmodule
